// File: rtl/timer_cntrl_pkg.sv
// Shared encodings for the multi-channel timer control block.
package timer_cntrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } ch_state_e;

    // status bit layout inside each channel's STAT_W slice
    localparam int STAT_PEND  = 0;
    localparam int STAT_ACT   = 1;
    localparam int STAT_ARM   = 2;
    localparam int STAT_DONE  = 3;
    localparam int STAT_USED  = 4;
    localparam int STAT_W_DEF = 8;

endpackage

// File: rtl/timer_cntrl_ch.sv
// One timer channel: IDLE/ARMED/ACTIVE control FSM with pending-gated reloads.
module timer_cntrl_ch
    import timer_cntrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 rst_req_i,
    input  logic                 update_i,
    input  logic                 oneshot_i,
    input  logic                 trig_en_i,
    input  logic                 trig_i,
    input  logic                 cnt_update_i,
    output logic                 ctrl_rst_o,
    output logic                 ctrl_cnt_upd_o,
    output logic                 ctrl_all_upd_o,
    output logic                 ctrl_active_o,
    output logic [STAT_USED-1:0] status_o
);

    ch_state_e state_q, state_d;
    logic      pending_q, pending_d;
    logic      done_q, done_d;
    logic      fire;
    logic      stop_eff;
    logic      is_active;

    assign is_active = (state_q == ST_ACTIVE);
    // start beats a coincident stop
    assign stop_eff  = stop_i & ~start_i;

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        fire    = 1'b0;
        if (start_i) done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (trig_en_i) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_ACTIVE;
                        fire    = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (stop_eff) begin
                    state_d = ST_IDLE;
                end else if (trig_i) begin
                    state_d = ST_ACTIVE;
                    fire    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (stop_eff) begin
                    state_d = ST_IDLE;
                end else if (cnt_update_i && oneshot_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // a fresh update request always survives a coincident clear
    assign pending_d = update_i | (pending_q & ~fire & ~(is_active & cnt_update_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        ctrl_rst_o     = 1'b0;
        ctrl_cnt_upd_o = 1'b0;
        ctrl_all_upd_o = 1'b0;
        ctrl_active_o  = 1'b0;
        status_o       = '0;
        if (!rst_i) begin
            ctrl_rst_o           = fire | rst_req_i;
            ctrl_cnt_upd_o       = fire | update_i;
            ctrl_all_upd_o       = fire | (cnt_update_i & pending_q & is_active);
            ctrl_active_o        = is_active;
            status_o[STAT_PEND]  = pending_q;
            status_o[STAT_ACT]   = is_active;
            status_o[STAT_ARM]   = (state_q == ST_ARMED);
            status_o[STAT_DONE]  = done_q;
        end
    end

endmodule

// File: rtl/timer_cntrl_mc.sv
// Multi-channel timer control: resolves group start/stop and fans out to channel FSMs.
module timer_cntrl_mc
    import timer_cntrl_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          cfg_start_i,
    input  logic [N_CH-1:0]          cfg_stop_i,
    input  logic [N_CH-1:0]          cfg_rst_i,
    input  logic [N_CH-1:0]          cfg_update_i,
    input  logic [N_CH-1:0]          cfg_arm_i,
    input  logic [N_CH-1:0]          cfg_oneshot_i,
    input  logic [N_CH-1:0]          cfg_trig_en_i,
    input  logic                     cfg_grp_start_i,
    input  logic                     cfg_grp_stop_i,
    input  logic [N_CH-1:0]          cfg_grp_mask_i,
    input  logic [N_CH-1:0]          trig_i,
    input  logic [N_CH-1:0]          cnt_update_i,
    output logic [N_CH-1:0]          ctrl_cnt_upd_o,
    output logic [N_CH-1:0]          ctrl_all_upd_o,
    output logic [N_CH-1:0]          ctrl_rst_o,
    output logic [N_CH-1:0]          ctrl_active_o,
    output logic [N_CH-1:0]          ctrl_arm_o,
    output logic [N_CH*STAT_W-1:0]   status_o
);

    logic [N_CH-1:0]                 st_eff;
    logic [N_CH-1:0]                 sp_eff;
    logic [N_CH-1:0][STAT_USED-1:0]  ch_stat;
    logic [N_CH-1:0][STAT_W-1:0]     stat;

    // group pulses hit every masked channel in the same cycle
    assign st_eff     = cfg_start_i | ({N_CH{cfg_grp_start_i}} & cfg_grp_mask_i);
    assign sp_eff     = cfg_stop_i  | ({N_CH{cfg_grp_stop_i}}  & cfg_grp_mask_i);
    assign ctrl_arm_o = cfg_arm_i;
    assign status_o   = stat;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        timer_cntrl_ch u_ch (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .start_i        (st_eff[c]),
            .stop_i         (sp_eff[c]),
            .rst_req_i      (cfg_rst_i[c]),
            .update_i       (cfg_update_i[c]),
            .oneshot_i      (cfg_oneshot_i[c]),
            .trig_en_i      (cfg_trig_en_i[c]),
            .trig_i         (trig_i[c]),
            .cnt_update_i   (cnt_update_i[c]),
            .ctrl_rst_o     (ctrl_rst_o[c]),
            .ctrl_cnt_upd_o (ctrl_cnt_upd_o[c]),
            .ctrl_all_upd_o (ctrl_all_upd_o[c]),
            .ctrl_active_o  (ctrl_active_o[c]),
            .status_o       (ch_stat[c])
        );
        assign stat[c] = {{(STAT_W-STAT_USED){1'b0}}, ch_stat[c]};
    end

endmodule

// File: tb/tb_timer_cntrl_mc.sv
// Directed scenarios plus randomized run against a behavioural channel model.
module tb_timer_cntrl_mc;
    localparam int N_CH   = 4;
    localparam int STAT_W = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [N_CH-1:0] cfg_start_i, cfg_stop_i, cfg_rst_i, cfg_update_i, cfg_arm_i;
    logic [N_CH-1:0] cfg_oneshot_i, cfg_trig_en_i, cfg_grp_mask_i, trig_i, cnt_update_i;
    logic cfg_grp_start_i, cfg_grp_stop_i;
    logic [N_CH-1:0] ctrl_cnt_upd_o, ctrl_all_upd_o, ctrl_rst_o, ctrl_active_o, ctrl_arm_o;
    logic [N_CH*STAT_W-1:0] status_o;

    int checks = 0;
    int failures = 0;

    // behavioural model: a channel is running, waiting for a trigger, or neither
    bit m_run [N_CH];
    bit m_wait[N_CH];
    bit m_pend[N_CH];
    bit m_done[N_CH];
    bit m_fire[N_CH];
    logic [N_CH-1:0] e_rst, e_cnt, e_all, e_act;
    logic [N_CH*STAT_W-1:0] e_stat;

    timer_cntrl_mc #(.N_CH(N_CH), .STAT_W(STAT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_rst_i(cfg_rst_i),
        .cfg_update_i(cfg_update_i), .cfg_arm_i(cfg_arm_i), .cfg_oneshot_i(cfg_oneshot_i),
        .cfg_trig_en_i(cfg_trig_en_i), .cfg_grp_start_i(cfg_grp_start_i),
        .cfg_grp_stop_i(cfg_grp_stop_i), .cfg_grp_mask_i(cfg_grp_mask_i),
        .trig_i(trig_i), .cnt_update_i(cnt_update_i),
        .ctrl_cnt_upd_o(ctrl_cnt_upd_o), .ctrl_all_upd_o(ctrl_all_upd_o),
        .ctrl_rst_o(ctrl_rst_o), .ctrl_active_o(ctrl_active_o),
        .ctrl_arm_o(ctrl_arm_o), .status_o(status_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit eff_st(int c);
        return cfg_start_i[c] | (cfg_grp_start_i & cfg_grp_mask_i[c]);
    endfunction

    function automatic bit eff_sp(int c);
        return cfg_stop_i[c] | (cfg_grp_stop_i & cfg_grp_mask_i[c]);
    endfunction

    task automatic model_outputs();
        e_stat = '0;
        for (int c = 0; c < N_CH; c++) begin
            bit st, sp, idle;
            st   = eff_st(c);
            sp   = eff_sp(c);
            idle = !m_run[c] && !m_wait[c];
            m_fire[c] = (idle && st && !cfg_trig_en_i[c]) || (m_wait[c] && trig_i[c] && !(sp && !st));
            e_rst[c] = !rst_i && (m_fire[c] || cfg_rst_i[c]);
            e_cnt[c] = !rst_i && (m_fire[c] || cfg_update_i[c]);
            e_all[c] = !rst_i && (m_fire[c] || (cnt_update_i[c] && m_pend[c] && m_run[c]));
            e_act[c] = !rst_i && m_run[c];
            if (!rst_i)
                e_stat[c*STAT_W +: STAT_W] = 8'(m_pend[c]) + 8'(m_run[c]) * 2 + 8'(m_wait[c]) * 4 + 8'(m_done[c]) * 8;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < N_CH; c++) begin
            bit st, sp, halt, shot;
            if (rst_i) begin
                m_run[c] = 0; m_wait[c] = 0; m_pend[c] = 0; m_done[c] = 0;
                continue;
            end
            st   = eff_st(c);
            sp   = eff_sp(c);
            halt = sp && !st;
            shot = m_run[c] && !halt && cnt_update_i[c] && cfg_oneshot_i[c];
            if (cfg_update_i[c]) m_pend[c] = 1;
            else if (m_fire[c] || (m_run[c] && cnt_update_i[c])) m_pend[c] = 0;
            if (shot) m_done[c] = 1;
            else if (st) m_done[c] = 0;
            if (m_run[c]) begin
                if (halt || shot) m_run[c] = 0;
            end else if (m_wait[c]) begin
                if (halt) m_wait[c] = 0;
                else if (trig_i[c]) begin m_wait[c] = 0; m_run[c] = 1; end
            end else if (st) begin
                if (cfg_trig_en_i[c]) m_wait[c] = 1;
                else m_run[c] = 1;
            end
        end
    endtask

    // inputs are driven 1 time unit after the rising edge; outputs sampled 2 units later
    task automatic settle();
        #2;
        model_outputs();
    endtask

    task automatic clock();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic clear_pulses();
        cfg_start_i = '0; cfg_stop_i = '0; cfg_rst_i = '0; cfg_update_i = '0;
        trig_i = '0; cnt_update_i = '0; cfg_grp_start_i = 0; cfg_grp_stop_i = 0;
    endtask

    task automatic test_reset();
        clear_pulses();
        cfg_arm_i = 4'b0110; cfg_oneshot_i = '0; cfg_trig_en_i = '0; cfg_grp_mask_i = '0;
        rst_i = 1;
        cfg_start_i = 4'b1111;
        settle();
        checks++; if (ctrl_rst_o !== 4'b0) begin failures++; $display("FAIL reset_rst got=%b exp=0000", ctrl_rst_o); end
        checks++; if (ctrl_active_o !== 4'b0) begin failures++; $display("FAIL reset_active got=%b exp=0000", ctrl_active_o); end
        checks++; if (status_o !== '0) begin failures++; $display("FAIL reset_status got=%h exp=0", status_o); end
        checks++; if (ctrl_arm_o !== 4'b0110) begin failures++; $display("FAIL reset_arm got=%b exp=0110", ctrl_arm_o); end
        clock();
        clock();
        rst_i = 0;
        clear_pulses();
        settle();
        checks++; if (status_o !== '0) begin failures++; $display("FAIL post_reset_status got=%h exp=0", status_o); end
    endtask

    task automatic test_start();
        cfg_start_i = 4'b0001;
        settle();
        checks++; if ({ctrl_rst_o, ctrl_cnt_upd_o, ctrl_all_upd_o} !== {3{4'b0001}}) begin
            failures++; $display("FAIL start_pulse got=%b/%b/%b exp=0001", ctrl_rst_o, ctrl_cnt_upd_o, ctrl_all_upd_o); end
        clock(); clear_pulses(); settle();
        checks++; if (ctrl_active_o !== 4'b0001) begin failures++; $display("FAIL start_active got=%b exp=0001", ctrl_active_o); end
        checks++; if (status_o[7:0] !== 8'h02) begin failures++; $display("FAIL start_status got=%h exp=02", status_o[7:0]); end
    endtask

    task automatic test_group();
        cfg_grp_mask_i = 4'b1010;
        cfg_grp_start_i = 1;
        settle();
        checks++; if (ctrl_rst_o !== 4'b1010) begin failures++; $display("FAIL grp_pulse got=%b exp=1010", ctrl_rst_o); end
        clock(); clear_pulses(); settle();
        checks++; if (ctrl_active_o !== 4'b1011) begin failures++; $display("FAIL grp_start got=%b exp=1011", ctrl_active_o); end
        cfg_grp_stop_i = 1;
        settle(); clock(); clear_pulses(); settle();
        checks++; if (ctrl_active_o !== 4'b0001) begin failures++; $display("FAIL grp_stop got=%b exp=0001", ctrl_active_o); end
        cfg_grp_mask_i = '0;
    endtask

    task automatic test_trigger();
        cfg_trig_en_i = 4'b0100;
        cfg_start_i = 4'b0100;
        settle();
        checks++; if (ctrl_all_upd_o[2] !== 1'b0 || ctrl_rst_o[2] !== 1'b0) begin
            failures++; $display("FAIL arm_no_pulse got=%b%b exp=00", ctrl_all_upd_o[2], ctrl_rst_o[2]); end
        clock(); clear_pulses(); settle();
        checks++; if (status_o[23:16] !== 8'h04) begin failures++; $display("FAIL armed_status got=%h exp=04", status_o[23:16]); end
        checks++; if (ctrl_active_o[2] !== 1'b0) begin failures++; $display("FAIL armed_active got=%b exp=0", ctrl_active_o[2]); end
        for (int i = 0; i < 4; i++) clock();
        trig_i = 4'b0100;
        settle();
        checks++; if ({ctrl_rst_o[2], ctrl_cnt_upd_o[2], ctrl_all_upd_o[2]} !== 3'b111) begin
            failures++; $display("FAIL trig_pulse got=%b%b%b exp=111", ctrl_rst_o[2], ctrl_cnt_upd_o[2], ctrl_all_upd_o[2]); end
        clock(); clear_pulses(); settle();
        checks++; if (status_o[23:16] !== 8'h02) begin failures++; $display("FAIL trig_status got=%h exp=02", status_o[23:16]); end
        cfg_stop_i = 4'b0100;
        settle(); clock(); clear_pulses();
        cfg_trig_en_i = '0;
        settle();
        checks++; if (ctrl_active_o !== 4'b0001) begin failures++; $display("FAIL trig_stop got=%b exp=0001", ctrl_active_o); end
    endtask

    task automatic test_oneshot();
        cfg_oneshot_i = 4'b0001;
        cnt_update_i = 4'b0001;
        settle();
        checks++; if (ctrl_all_upd_o[0] !== 1'b0) begin failures++; $display("FAIL oneshot_all got=%b exp=0", ctrl_all_upd_o[0]); end
        clock(); clear_pulses(); settle();
        checks++; if (ctrl_active_o[0] !== 1'b0) begin failures++; $display("FAIL oneshot_active got=%b exp=0", ctrl_active_o[0]); end
        checks++; if (status_o[7:0] !== 8'h08) begin failures++; $display("FAIL oneshot_done got=%h exp=08", status_o[7:0]); end
        cfg_oneshot_i = '0;
        cnt_update_i = 4'b0001;
        settle(); clock(); clear_pulses(); settle();
        checks++; if (status_o[7:0] !== 8'h08) begin failures++; $display("FAIL idle_cnt_ignored got=%h exp=08", status_o[7:0]); end
        cfg_start_i = 4'b0001;
        settle(); clock(); clear_pulses(); settle();
        checks++; if (status_o[7:0] !== 8'h02) begin failures++; $display("FAIL restart_clears_done got=%h exp=02", status_o[7:0]); end
    endtask

    task automatic test_pending();
        cnt_update_i = 4'b0001;
        settle();
        checks++; if (ctrl_all_upd_o[0] !== 1'b0) begin failures++; $display("FAIL nopend_all got=%b exp=0", ctrl_all_upd_o[0]); end
        clock(); clear_pulses();
        cfg_update_i = 4'b0001;
        settle();
        checks++; if (ctrl_cnt_upd_o !== 4'b0001) begin failures++; $display("FAIL upd_cnt got=%b exp=0001", ctrl_cnt_upd_o); end
        clock(); clear_pulses(); settle();
        checks++; if (status_o[7:0] !== 8'h03) begin failures++; $display("FAIL pend_set got=%h exp=03", status_o[7:0]); end
        cnt_update_i = 4'b0001;
        settle();
        checks++; if (ctrl_all_upd_o[0] !== 1'b1) begin failures++; $display("FAIL pend_all got=%b exp=1", ctrl_all_upd_o[0]); end
        clock(); clear_pulses(); settle();
        checks++; if (status_o[7:0] !== 8'h02) begin failures++; $display("FAIL pend_clear got=%h exp=02", status_o[7:0]); end
        cfg_update_i = 4'b0001;
        settle(); clock(); clear_pulses();
        cfg_update_i = 4'b0001; cnt_update_i = 4'b0001;
        settle();
        checks++; if (ctrl_all_upd_o[0] !== 1'b1) begin failures++; $display("FAIL both_all got=%b exp=1", ctrl_all_upd_o[0]); end
        clock(); clear_pulses(); settle();
        checks++; if (status_o[7:0] !== 8'h03) begin failures++; $display("FAIL both_keep_pend got=%h exp=03", status_o[7:0]); end
    endtask

    task automatic test_reset_mid();
        cfg_start_i = 4'b0110;
        settle(); clock(); clear_pulses(); settle();
        checks++; if (ctrl_active_o !== 4'b0111) begin failures++; $display("FAIL three_active got=%b exp=0111", ctrl_active_o); end
        rst_i = 1; cfg_start_i = 4'b1000; cfg_update_i = 4'b1111; cnt_update_i = 4'b1111;
        settle();
        checks++; if ({ctrl_rst_o, ctrl_cnt_upd_o, ctrl_all_upd_o, ctrl_active_o} !== 16'h0) begin
            failures++; $display("FAIL in_reset_out got=%h exp=0", {ctrl_rst_o, ctrl_cnt_upd_o, ctrl_all_upd_o, ctrl_active_o}); end
        checks++; if (status_o !== '0) begin failures++; $display("FAIL in_reset_status got=%h exp=0", status_o); end
        clock(); rst_i = 0; clear_pulses(); settle();
        checks++; if (ctrl_active_o !== 4'b0) begin failures++; $display("FAIL after_reset_active got=%b exp=0000", ctrl_active_o); end
        checks++; if (status_o !== '0) begin failures++; $display("FAIL after_reset_status got=%h exp=0", status_o); end
        cfg_start_i = 4'b1000; cfg_stop_i = 4'b1000;
        settle();
        checks++; if (ctrl_rst_o !== 4'b1000) begin failures++; $display("FAIL startstop_pulse got=%b exp=1000", ctrl_rst_o); end
        clock(); clear_pulses(); settle();
        checks++; if (ctrl_active_o !== 4'b1000) begin failures++; $display("FAIL startstop_active got=%b exp=1000", ctrl_active_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst_i = ($urandom_range(0, 79) == 0);
            for (int c = 0; c < N_CH; c++) begin
                cfg_start_i[c]   = ($urandom_range(0, 7) == 0);
                cfg_stop_i[c]    = ($urandom_range(0, 11) == 0);
                cfg_rst_i[c]     = ($urandom_range(0, 5) == 0);
                cfg_update_i[c]  = ($urandom_range(0, 5) == 0);
                cfg_arm_i[c]     = 1'($urandom);
                trig_i[c]        = ($urandom_range(0, 5) == 0);
                cnt_update_i[c]  = ($urandom_range(0, 3) == 0);
            end
            if (n % 16 == 0) begin
                cfg_grp_mask_i = 4'($urandom);
                cfg_oneshot_i  = 4'($urandom);
                cfg_trig_en_i  = 4'($urandom);
            end
            cfg_grp_start_i = ($urandom_range(0, 11) == 0);
            cfg_grp_stop_i  = ($urandom_range(0, 13) == 0);
            settle();
            checks++; if (ctrl_rst_o !== e_rst) begin failures++; $display("FAIL rnd_rst n=%0d got=%b exp=%b", n, ctrl_rst_o, e_rst); end
            checks++; if (ctrl_cnt_upd_o !== e_cnt) begin failures++; $display("FAIL rnd_cnt_upd n=%0d got=%b exp=%b", n, ctrl_cnt_upd_o, e_cnt); end
            checks++; if (ctrl_all_upd_o !== e_all) begin failures++; $display("FAIL rnd_all_upd n=%0d got=%b exp=%b", n, ctrl_all_upd_o, e_all); end
            checks++; if (ctrl_active_o !== e_act) begin failures++; $display("FAIL rnd_active n=%0d got=%b exp=%b", n, ctrl_active_o, e_act); end
            checks++; if (ctrl_arm_o !== cfg_arm_i) begin failures++; $display("FAIL rnd_arm n=%0d got=%b exp=%b", n, ctrl_arm_o, cfg_arm_i); end
            checks++; if (status_o !== e_stat) begin failures++; $display("FAIL rnd_status n=%0d got=%h exp=%h", n, status_o, e_stat); end
            clock();
        end
        rst_i = 0;
        clear_pulses();
    endtask

    initial begin
        #1;
        test_reset();
        test_start();
        test_group();
        test_trigger();
        test_oneshot();
        test_pending();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
